gmii_axis_rx: RTL and testbench

//  GMII/MII frame receiver, the receive-side partner of the GMII transmitter: GMII in, AXI4-Stream out.

---
 rtl/gmii_axis_rx.sv | 205 ++++++++++++++++++++
 tb/tb_gmii_axis_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_axis_rx.sv
// GMII/MII frame receiver: strips preamble/SFD, checks and strips the FCS,
// and emits payload bytes as single-cycle AXI4-Stream beats (no backpressure).
// Bad frames are flagged on tuser with tlast and on the two error pulses.
module gmii_axis_rx #(
    parameter int MIN_FRAME_LENGTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
    input  logic       clk_enable,
    input  logic       mii_select,
    output logic [7:0] output_axis_tdata,
    output logic       output_axis_tvalid,
    output logic       output_axis_tlast,
    output logic       output_axis_tuser,
    output logic       error_bad_frame,
    output logic       error_bad_fcs
);

    typedef enum logic {
        ST_IDLE,
        ST_PAYLOAD
    } state_t;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [15:0] MIN_LEN     = 16'(MIN_FRAME_LENGTH);

    // Reflected CRC-32 (poly 04C11DB7), one data byte, LSB first.
    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
            else                c = c >> 1;
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [7:0]  dly_q [5];
    logic [7:0]  dly_d [5];
    logic [2:0]  fill_q, fill_d;
    logic [15:0] ptr_q, ptr_d;
    logic        bad_q, bad_d;
    logic        phase_q, phase_d;     // MII: 1 while waiting for the high nibble
    logic [3:0]  nib_lo_q, nib_lo_d;
    logic        lo_dv_q, lo_dv_d;     // MII: dv seen with the low nibble
    logic        prev5_q, prev5_d;     // MII: previous idle nibble was 5 with dv
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        ebf_q, ebf_d;
    logic        efcs_q, efcs_d;

    logic [7:0]  rx_byte;
    logic        byte_cycle;
    logic        sfd_det;
    logic        fcs_bad;
    logic        frame_bad;

    // Byte assembly and SFD detection for both GMII and MII modes.
    always_comb begin
        rx_byte    = mii_select ? {gmii_rxd[3:0], nib_lo_q} : gmii_rxd;
        byte_cycle = clk_enable & (~mii_select | phase_q);
        sfd_det    = clk_enable & gmii_rx_dv &
                     (mii_select ? (gmii_rxd[3:0] == 4'hD && prev5_q) : (gmii_rxd == 8'hD5));
        fcs_bad    = (crc_q != CRC_RESIDUE);
        frame_bad  = bad_q | (ptr_q < MIN_LEN) | (mii_select & lo_dv_q);
    end

    // Next-state and output logic; the whole frame state advances only on
    // byte-cycles, so in MII mode end-of-frame is seen on the second nibble.
    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        dly_d    = dly_q;
        fill_d   = fill_q;
        ptr_d    = ptr_q;
        bad_d    = bad_q;
        phase_d  = phase_q;
        nib_lo_d = nib_lo_q;
        lo_dv_d  = lo_dv_q;
        prev5_d  = prev5_q;
        tdata_d  = tdata_q;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
        ebf_d    = 1'b0;
        efcs_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clk_enable) begin
                    prev5_d = gmii_rx_dv && (gmii_rxd[3:0] == 4'h5);
                end
                if (sfd_det) begin
                    state_d = ST_PAYLOAD;
                    crc_d   = '1;
                    fill_d  = '0;
                    ptr_d   = '0;
                    bad_d   = 1'b0;
                    phase_d = 1'b0;
                    lo_dv_d = 1'b0;
                end
            end

            ST_PAYLOAD: begin
                if (clk_enable && gmii_rx_dv && gmii_rx_er) begin
                    bad_d = 1'b1;
                end
                if (clk_enable && mii_select) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        nib_lo_d = gmii_rxd[3:0];
                        lo_dv_d  = gmii_rx_dv;
                    end
                end
                if (byte_cycle) begin
                    if (gmii_rx_dv) begin
                        dly_d[0] = rx_byte;
                        for (int unsigned i = 1; i < 5; i++) begin
                            dly_d[i] = dly_q[i-1];
                        end
                        crc_d = crc_next(crc_q, rx_byte);
                        if (ptr_q != 16'hFFFF) ptr_d = ptr_q + 16'd1;
                        if (fill_q == 3'd5) begin
                            tdata_d  = dly_q[4];
                            tvalid_d = 1'b1;
                        end else begin
                            fill_d = fill_q + 3'd1;
                        end
                    end else begin
                        if (fill_q == 3'd5) begin
                            tdata_d  = dly_q[4];
                            tvalid_d = 1'b1;
                            tlast_d  = 1'b1;
                            tuser_d  = fcs_bad | frame_bad;
                            efcs_d   = fcs_bad;
                            ebf_d    = frame_bad;
                        end else begin
                            ebf_d = 1'b1;
                        end
                        state_d = ST_IDLE;
                        prev5_d = 1'b0;
                        phase_d = 1'b0;
                        lo_dv_d = 1'b0;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            crc_q    <= '1;
            dly_q    <= '{default: '0};
            fill_q   <= '0;
            ptr_q    <= '0;
            bad_q    <= 1'b0;
            phase_q  <= 1'b0;
            nib_lo_q <= '0;
            lo_dv_q  <= 1'b0;
            prev5_q  <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            ebf_q    <= 1'b0;
            efcs_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            dly_q    <= dly_d;
            fill_q   <= fill_d;
            ptr_q    <= ptr_d;
            bad_q    <= bad_d;
            phase_q  <= phase_d;
            nib_lo_q <= nib_lo_d;
            lo_dv_q  <= lo_dv_d;
            prev5_q  <= prev5_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            ebf_q    <= ebf_d;
            efcs_q   <= efcs_d;
        end
    end

    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign output_axis_tlast  = tlast_q;
    assign output_axis_tuser  = tuser_q;
    assign error_bad_frame    = ebf_q;
    assign error_bad_fcs      = efcs_q;

endmodule

// File: tb/tb_gmii_axis_rx.sv
// Randomized self-checking bench for gmii_axis_rx with a frame-level model.
module tb_gmii_axis_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rxd;
    logic       dv, er, ce, mii;
    logic [7:0] tdata;
    logic       tvalid, tlast, tuser, ebf, efcs;

    gmii_axis_rx #(.MIN_FRAME_LENGTH(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .gmii_rxd          (rxd),
        .gmii_rx_dv        (dv),
        .gmii_rx_er        (er),
        .clk_enable        (ce),
        .mii_select        (mii),
        .output_axis_tdata (tdata),
        .output_axis_tvalid(tvalid),
        .output_axis_tlast (tlast),
        .output_axis_tuser (tuser),
        .error_bad_frame   (ebf),
        .error_bad_fcs     (efcs)
    );

    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic       has_beat;
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       efcs;
        logic       eframe;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  beat_cnt = 0;
    logic prev_tv = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Standard Ethernet CRC-32 (final value complemented, as transmitted).
    function automatic logic [31:0] crc32(input bq_t b);
        logic [31:0] c;
        c = '1;
        foreach (b[i]) begin
            c ^= {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic bq_t mk_frame(input int len, input bit inc);
        bq_t b;
        logic [31:0] f;
        for (int i = 0; i < len; i++) b.push_back(inc ? 8'(i) : 8'($urandom));
        f = crc32(b);
        b.push_back(f[7:0]);
        b.push_back(f[15:8]);
        b.push_back(f[23:16]);
        b.push_back(f[31:24]);
        return b;
    endfunction

    // Expected output for a frame of post-SFD bytes b: the last four bytes are
    // the FCS; everything before them is forwarded, tagged at the end.
    function automatic void model_frame(input bq_t b, input bit er_seen, input bit odd);
        int n;
        bq_t pl;
        logic [31:0] rx_fcs;
        bit fcs_bad, fr_bad;
        n = b.size();
        if (n < 5) begin
            exp_q.push_back(ev_t'{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
        end else begin
            pl      = b[0:n-5];
            rx_fcs  = {b[n-1], b[n-2], b[n-3], b[n-4]};
            fcs_bad = (crc32(pl) != rx_fcs);
            fr_bad  = er_seen | odd | (n < 64);
            for (int i = 0; i <= n - 5; i++) begin
                if (i == n - 5)
                    exp_q.push_back(ev_t'{1'b1, b[i], 1'b1, fcs_bad | fr_bad, fcs_bad, fr_bad});
                else
                    exp_q.push_back(ev_t'{1'b1, b[i], 1'b0, 1'b0, 1'b0, 1'b0});
            end
        end
    endfunction

    task automatic drive(input logic [7:0] d, input logic v, input logic e, input bit gaps);
        int g;
        if (gaps) begin
            g = $urandom_range(0, 2);
            for (int i = 0; i < g; i++) begin
                @(negedge clk);
                ce = 1'b0; rxd = 8'($urandom); dv = 1'($urandom); er = 1'($urandom);
            end
        end
        @(negedge clk);
        ce = 1'b1; rxd = d; dv = v; er = e;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic e, input bit m, input bit gaps);
        if (!m) begin
            drive(b, 1'b1, e, gaps);
        end else begin
            drive({4'($urandom), b[3:0]}, 1'b1, e, gaps);
            drive({4'($urandom), b[7:4]}, 1'b1, e, gaps);
        end
    endtask

    task automatic send_frame(input bq_t b, input bit m, input int er_idx, input bit odd,
                              input bit gaps, input int rst_at);
        if (rst_at < 0) model_frame(b, er_idx >= 0, odd);
        else for (int i = 0; i < rst_at - 5; i++) exp_q.push_back(ev_t'{1'b1, b[i], 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        mii = m; ce = 1'b1; dv = 1'b0; er = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'h55, 1'b0, m, gaps);
        send_byte(8'hD5, 1'b0, m, gaps);
        for (int i = 0; i < b.size(); i++) begin
            if (i == rst_at) begin
                @(negedge clk);
                rst = 1'b1; dv = 1'b0; er = 1'b0; ce = 1'b1;
                @(posedge clk);
                #1;
                chk("rst_tvalid", tvalid, 0);
                chk("rst_tlast", tlast, 0);
                chk("rst_tuser", tuser, 0);
                chk("rst_ebf", ebf, 0);
                chk("rst_efcs", efcs, 0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            send_byte(b[i], 1'(i == er_idx), m, gaps);
        end
        if (odd && rst_at < 0) drive(8'($urandom), 1'b1, 1'b0, gaps);
        for (int i = 0; i < 12; i++) drive(8'($urandom), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    // Compare every output cycle against the model's event queue.
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk);
            #1;
            if (tvalid || ebf || efcs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {29'd0, tvalid, ebf, efcs}, 0);
                end else begin
                    ev = exp_q.pop_front();
                    chk("tvalid", tvalid, ev.has_beat);
                    if (ev.has_beat) chk("tdata", tdata, ev.data);
                    chk("tlast", tlast, ev.last);
                    chk("tuser", tuser, ev.user);
                    chk("err_fcs", efcs, ev.efcs);
                    chk("err_frame", ebf, ev.eframe);
                end
                if (tvalid) beat_cnt++;
            end
            if (tvalid && mii) chk("mii_beat_gap", prev_tv, 0);
            prev_tv = tvalid;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t f, s;
        int b0, len, er_idx;
        bit m, odd, gaps;

        rst = 1'b1; ce = 1'b1; dv = 1'b0; er = 1'b0; rxd = '0; mii = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tdata", tdata, 0);
        chk("reset_tvalid", tvalid, 0);
        chk("reset_tlast", tlast, 0);
        chk("reset_tuser", tuser, 0);
        chk("reset_errs", {ebf, efcs}, 0);
        @(negedge clk);
        rst = 1'b0;

        s = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("crc_pin", crc32(s), 32'hCBF43926);

        // 1: good GMII frame, payload 00..3B
        f = mk_frame(60, 1'b1);
        chk("t1_fcs_pin", {f[63], f[62], f[61], f[60]}, crc32(f[0:59]));
        b0 = beat_cnt;
        send_frame(f, 1'b0, -1, 1'b0, 1'b0, -1);
        wait_drain();
        chk("t1_beats", beat_cnt - b0, 60);

        // 2: corrupted FCS
        f[60] = f[60] ^ 8'h01;
        send_frame(f, 1'b0, -1, 1'b0, 1'b0, -1);
        wait_drain();

        // 3: rx_er on payload byte 10
        f = mk_frame(60, 1'b1);
        send_frame(f, 1'b0, 10, 1'b0, 1'b0, -1);
        wait_drain();

        // 4: runt and 3-byte burst
        send_frame(mk_frame(20, 1'b1), 1'b0, -1, 1'b0, 1'b0, -1);
        s = {8'($urandom), 8'($urandom), 8'($urandom)};
        send_frame(s, 1'b0, -1, 1'b0, 1'b0, -1);
        wait_drain();

        // 5: MII frame, then MII frame with a trailing odd nibble
        b0 = beat_cnt;
        send_frame(f, 1'b1, -1, 1'b0, 1'b0, -1);
        wait_drain();
        chk("t5_beats", beat_cnt - b0, 60);
        send_frame(f, 1'b1, -1, 1'b1, 1'b0, -1);
        wait_drain();

        // 6: reset mid-frame at byte 30, then a clean frame
        send_frame(f, 1'b0, -1, 1'b0, 1'b0, 30);
        b0 = beat_cnt;
        send_frame(f, 1'b0, -1, 1'b0, 1'b0, -1);
        wait_drain();
        chk("t6_beats", beat_cnt - b0, 60);

        // Randomized frames
        for (int n = 0; n < 30; n++) begin
            m    = 1'($urandom);
            gaps = 1'($urandom);
            odd  = m && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                s.delete();
                len = $urandom_range(1, 4);
                for (int i = 0; i < len; i++) s.push_back(8'($urandom));
                f = s;
            end else begin
                f = mk_frame($urandom_range(1, 90), 1'b0);
                if ($urandom_range(0, 4) == 0) f[f.size() - 1 - $urandom_range(0, 3)] ^= 8'(1 << $urandom_range(0, 7));
            end
            er_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, f.size() - 1)) : -1;
            send_frame(f, m, er_idx, odd, gaps, -1);
        end
        wait_drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
